// File: rtl/adc_scan_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : adc_scan_sequencer_if
// Description : Frame-level command/response link between the scan sequencer
//               and the LTC2308 SPI frame engine.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface adc_scan_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_cfg;
  logic        rsp_valid;
  logic [11:0] rsp_data;

  modport master (
    output cmd_valid,
    output cmd_cfg,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  cmd_valid,
    input  cmd_cfg,
    output cmd_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
//------------------------------------------------------------------------------
// Module      : adc_scan_sequencer
// Description : Periodic multi-channel LTC2308 scan sequencer; realigns the
//               one-frame-late results to their channels and holds them.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adc_scan_sequencer #(
  parameter int SCAN_DIV = 50000,
  parameter int TIMEOUT  = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [7:0]            chan_mask,
  input  logic                  unipolar,
  input  logic                  clr_err,
  adc_scan_sequencer_if.master  bus,
  input  logic [2:0]            rd_ch,
  output logic [11:0]           rd_data,
  output logic                  rd_valid,
  output logic                  scan_done,
  output logic [15:0]           scan_count,
  output logic                  overrun,
  output logic                  timeout_err
);

  localparam int                  c_DIV_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int                  c_TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [c_DIV_W-1:0]  c_DIV_LOAD  = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_NEXT     = 2'd3
  } state_t;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

  function automatic logic [5:0] cfg_word(input logic [2:0] c, input logic uni);
    cfg_word = {1'b1, c[0], c[2], c[1], uni, 1'b0};
  endfunction

  state_t              r_state, w_state_nxt;
  logic [c_DIV_W-1:0]  r_tick_cnt;
  logic [c_TO_W-1:0]   r_to_cnt;
  logic [7:0]          r_scan_mask;
  logic [2:0]          r_ch;
  logic [2:0]          r_issued_ch;
  logic [2:0]          r_store_ch;
  logic                r_first;
  logic                r_flushed;
  logic [5:0]          r_cfg;
  logic [11:0]         r_result [8];
  logic [7:0]          r_valid;
  logic                r_scan_done;
  logic [15:0]         r_scan_count;
  logic                r_overrun;
  logic                r_timeout_err;

  logic                w_tick;
  logic [7:0]          w_higher;
  logic                w_start, w_accept, w_store, w_timeout, w_advance, w_flush, w_done;

  assign w_tick   = enable && (r_tick_cnt == '0);
  // Channels of the latched mask strictly above the current one.
  assign w_higher = r_scan_mask & ~((8'd2 << r_ch) - 8'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_store     = 1'b0;
    w_timeout   = 1'b0;
    w_advance   = 1'b0;
    w_flush     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick && (chan_mask != '0)) begin
          w_start     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (bus.rsp_valid) begin
          w_store     = !r_first;
          w_state_nxt = S_NEXT;
        end else if (r_to_cnt == c_TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_NEXT: begin
        if (w_higher != '0) begin
          w_advance   = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (!r_flushed) begin
          w_flush     = 1'b1;
          w_state_nxt = S_ISSUE;
        end else begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt    <= c_DIV_LOAD;
      r_to_cnt      <= '0;
      r_scan_mask   <= '0;
      r_ch          <= '0;
      r_issued_ch   <= '0;
      r_store_ch    <= '0;
      r_first       <= 1'b0;
      r_flushed     <= 1'b0;
      r_cfg         <= '0;
      r_valid       <= '0;
      r_scan_done   <= 1'b0;
      r_scan_count  <= '0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
      for (int i = 0; i < 8; i++) r_result[i] <= '0;
    end else begin
      if (!enable || (r_tick_cnt == '0)) r_tick_cnt <= c_DIV_LOAD;
      else                               r_tick_cnt <= r_tick_cnt - 1'b1;

      if (w_start) begin
        r_scan_mask <= chan_mask;
        r_ch        <= lowest_set(chan_mask);
        r_cfg       <= cfg_word(lowest_set(chan_mask), unipolar);
        r_first     <= 1'b1;
        r_flushed   <= 1'b0;
      end
      if (w_advance) begin
        r_ch  <= lowest_set(w_higher);
        r_cfg <= cfg_word(lowest_set(w_higher), unipolar);
      end
      // The flush frame repeats the last channel only to clock out its result.
      if (w_flush) begin
        r_flushed <= 1'b1;
        r_cfg     <= cfg_word(r_ch, unipolar);
      end

      if (w_accept) begin
        r_to_cnt    <= '0;
        r_issued_ch <= r_ch;
        r_store_ch  <= r_issued_ch;
      end else if (r_state == S_WAIT_RSP) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if ((r_state == S_WAIT_RSP) && bus.rsp_valid) r_first <= 1'b0;
      if (w_store) begin
        r_result[r_store_ch] <= bus.rsp_data;
        r_valid[r_store_ch]  <= 1'b1;
      end

      r_scan_done <= w_done;
      if (w_done) r_scan_count <= r_scan_count + 1'b1;

      // A new error in the same cycle as clr_err keeps the flag set.
      if (w_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
      else if (clr_err)                  r_overrun <= 1'b0;
      if (w_timeout)    r_timeout_err <= 1'b1;
      else if (clr_err) r_timeout_err <= 1'b0;
    end
  end

  assign bus.cmd_valid = (r_state == S_ISSUE);
  assign bus.cmd_cfg   = r_cfg;
  assign rd_data       = r_result[rd_ch];
  assign rd_valid      = r_valid[rd_ch];
  assign scan_done     = r_scan_done;
  assign scan_count    = r_scan_count;
  assign overrun       = r_overrun;
  assign timeout_err   = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_adc_scan_sequencer
// Description : Self-checking bench: table of scans plus timeout, overrun and
//               reset corner sequences against an auto-responding frame engine.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_adc_scan_sequencer;

  localparam int SCAN_DIV = 20;
  localparam int TIMEOUT  = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable, unipolar, clr_err;
  logic [7:0]  chan_mask;
  logic [2:0]  rd_ch;
  logic [11:0] rd_data;
  logic        rd_valid, scan_done, overrun, timeout_err;
  logic [15:0] scan_count;

  always #5 clk = ~clk;

  adc_scan_sequencer_if bus();

  adc_scan_sequencer #(.SCAN_DIV(SCAN_DIV), .TIMEOUT(TIMEOUT)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .chan_mask   (chan_mask),
    .unipolar    (unipolar),
    .clr_err     (clr_err),
    .bus         (bus),
    .rd_ch       (rd_ch),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .scan_done   (scan_done),
    .scan_count  (scan_count),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [2:0]  exp_q [$];
  logic [11:0] rsp_q [$];
  bit          exp_uni;
  logic [11:0] m_res [8];
  bit          m_val [8];
  logic [2:0]  m_cur, m_prev;
  int          frame_idx = 0;
  bit          model_on = 1'b1, mute = 1'b0, block_ready = 1'b0;
  int          latency = 1;
  int          n_accept = 0;
  int          accept_cyc = 0;
  int          done_cnt = 0;
  int          cyc = 0;

  typedef struct {
    logic [7:0] mask;
    bit         uni;
    int         frames;
    logic [7:0] mask_after;
  } vec_t;
  vec_t vecs [6];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (scan_done) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame engine: accepts on the cycle after cmd_valid is seen, answers after
  // `latency` cycles; the scoreboard pops the expected channel on accept.
  initial begin : responder
    logic [5:0]  cfg;
    logic [2:0]  ch;
    logic [11:0] d;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.cmd_valid && !block_ready) begin
        cfg = bus.cmd_cfg;
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        n_accept++;
        accept_cyc = cyc;
        if (model_on) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame: got cfg 0x%0h, expected no frame", cfg);
          end else begin
            ch = exp_q.pop_front();
            check("cmd_cfg", 32'(cfg), 32'({1'b1, ch[0], ch[2], ch[1], exp_uni, 1'b0}));
            m_prev = m_cur;
            m_cur  = ch;
          end
        end
        if (!mute) begin
          repeat (latency - 1) @(negedge clk);
          if (rsp_q.size() != 0) d = rsp_q.pop_front();
          else if (model_on)     d = 12'($urandom_range(0, 4095));
          else                   d = 12'h5A5;
          bus.rsp_data  = d;
          bus.rsp_valid = 1'b1;
          if (model_on) begin
            if (frame_idx > 0) begin
              m_res[m_prev] = d;
              m_val[m_prev] = 1'b1;
            end
            frame_idx++;
          end
          @(negedge clk);
          bus.rsp_valid = 1'b0;
        end
      end
    end
  end

  task automatic expect_scan(input logic [7:0] mask, input bit uni);
    logic [2:0] last;
    last = 3'd0;
    exp_q.delete();
    exp_uni   = uni;
    frame_idx = 0;
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) begin
        exp_q.push_back(3'(c));
        last = 3'(c);
      end
    end
    exp_q.push_back(last);
  endtask

  task automatic check_results(input string tag);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rd_ch = 3'(c);
      #1;
      check($sformatf("%s_rd_data_ch%0d", tag, c), 32'(rd_data), 32'(m_res[c]));
      check($sformatf("%s_rd_valid_ch%0d", tag, c), 32'(rd_valid), 32'(m_val[c]));
    end
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!bus.cmd_valid && n < 3 * SCAN_DIV) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start"}, 32'(bus.cmd_valid), 32'd1);
  endtask

  task automatic run_scan(input vec_t v, input string tag);
    int sc0, d0, a0, n;
    chan_mask = v.mask;
    unipolar  = v.uni;
    expect_scan(v.mask, v.uni);
    sc0 = int'(scan_count);
    d0  = done_cnt;
    a0  = n_accept;
    enable = 1'b1;
    wait_start(tag);
    enable    = 1'b0;
    chan_mask = v.mask_after;
    n = 0;
    while (done_cnt == d0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_scan_count"}, 32'(scan_count), 32'(sc0 + 1));
    check({tag, "_frames"}, 32'(n_accept - a0), 32'(v.frames));
    check({tag, "_frames_left"}, 32'(exp_q.size()), 32'd0);
    check_results(tag);
  endtask

  initial begin : main
    int sc0, d0, a0, n, t_cyc;
    vecs[0] = '{8'h01, 1'b1, 2, 8'h01};
    vecs[1] = '{8'hA5, 1'b0, 5, 8'hA5};
    vecs[2] = '{8'h80, 1'b1, 2, 8'h80};
    vecs[3] = '{8'hFF, 1'b0, 9, 8'hFF};
    vecs[4] = '{8'h18, 1'b1, 3, 8'h18};
    vecs[5] = '{8'h06, 1'b0, 3, 8'hFF};

    enable = 1'b0; chan_mask = '0; unipolar = 1'b0; clr_err = 1'b0; rd_ch = '0;
    for (int c = 0; c < 8; c++) begin
      m_res[c] = '0;
      m_val[c] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst_scan_count", 32'(scan_count), 32'd0);
    check("rst_flags", 32'({overrun, timeout_err, scan_done}), 32'd0);
    check("rst_rd", 32'({rd_valid, rd_data}), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Table of scans; the last entry changes the mask mid-scan.
    rsp_q.push_back(12'hAAA);
    rsp_q.push_back(12'h123);
    for (int i = 0; i < 6; i++) begin
      run_scan(vecs[i], $sformatf("v%0d", i));
      if (i == 0) begin
        rd_ch = 3'd0;
        #1;
        check("v0_ch0_value", 32'(rd_data), 32'h123);
      end
    end
    a0 = n_accept;
    repeat (3 * SCAN_DIV) @(negedge clk);
    check("no_scan_after_disable", 32'(n_accept - a0), 32'd0);

    // Empty mask: ticks are ignored, no frames, no overrun.
    chan_mask = 8'h00;
    enable = 1'b1;
    a0 = n_accept;
    sc0 = int'(scan_count);
    repeat (3 * SCAN_DIV) @(negedge clk);
    enable = 1'b0;
    check("mask0_frames", 32'(n_accept - a0), 32'd0);
    check("mask0_overrun", 32'(overrun), 32'd0);
    check("mask0_scan_count", 32'(scan_count), 32'(sc0));

    // Overrun: slow responder, scans longer than the tick period.
    model_on = 1'b0;
    latency  = 15;
    chan_mask = 8'h01;
    sc0 = int'(scan_count);
    d0  = done_cnt;
    enable = 1'b1;
    n = 0;
    while (!overrun && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ovr_set", 32'(overrun), 32'd1);
    n = 0;
    while (int'(scan_count) < sc0 + 2 && n < 600) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("ovr_scan_count", 32'(scan_count), 32'(sc0 + 2));
    check("ovr_done_pulses", 32'(done_cnt - d0), 32'd2);
    enable = 1'b0;
    repeat (100) @(negedge clk);
    check("ovr_sticky", 32'(overrun), 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("ovr_cleared", 32'({overrun, timeout_err}), 32'd0);
    m_res[0] = 12'h5A5;
    m_val[0] = 1'b1;
    check_results("ovr");
    model_on = 1'b1;
    latency  = 1;

    // Timeout: responder accepts but never answers.
    mute = 1'b1;
    chan_mask = 8'h02;
    unipolar  = 1'b1;
    expect_scan(8'h02, 1'b1);
    sc0 = int'(scan_count);
    d0  = done_cnt;
    enable = 1'b1;
    wait_start("to");
    enable = 1'b0;
    n = 0;
    while (!timeout_err && n < 4 * TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    t_cyc = cyc;
    check("to_flag", 32'(timeout_err), 32'd1);
    check("to_latency", 32'(t_cyc - accept_cyc), 32'(TIMEOUT));
    repeat (3) @(negedge clk);
    check("to_idle", 32'(bus.cmd_valid), 32'd0);
    check("to_scan_count", 32'(scan_count), 32'(sc0));
    check("to_no_done", 32'(done_cnt - d0), 32'd0);
    exp_q.delete();
    mute = 1'b0;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("to_cleared", 32'(timeout_err), 32'd0);
    run_scan('{8'h02, 1'b1, 2, 8'h02}, "to_recover");

    // Reset while a command is stalled.
    block_ready = 1'b1;
    chan_mask = 8'h01;
    unipolar  = 1'b0;
    enable = 1'b1;
    wait_start("rst");
    repeat (2) @(negedge clk);
    check("rst_stalled", 32'(bus.cmd_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst_async_cfg", 32'(bus.cmd_cfg), 32'd0);
    check("rst_async_count", 32'(scan_count), 32'd0);
    check("rst_async_flags", 32'({overrun, timeout_err, scan_done}), 32'd0);
    for (int c = 0; c < 8; c++) begin
      m_res[c] = '0;
      m_val[c] = 1'b0;
    end
    check_results("rst");
    block_ready = 1'b0;
    expect_scan(8'h01, 1'b0);
    d0 = done_cnt;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (!bus.cmd_valid && n < 3 * SCAN_DIV) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    check("rst_first_tick", 32'(n), 32'(SCAN_DIV));
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("rst_scan_count", 32'(scan_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
